// File: rtl/signal_delay_measurement.sv
// signal_delay_measurement
//   Measures the number of clock ticks between a rising edge on original_signal
//   and the matching rising edge on delayed_signal. Reports the result with a
//   one-cycle measurement_valid pulse, or a one-cycle timeout pulse when no
//   delayed edge is seen within TIMEOUT_TICKS ticks.
//   Optional build macro: SIGNAL_DELAY_MEASUREMENT_CONTINUOUS_EN. When it is
//   defined the block re-arms itself after every result and never waits for
//   start.
module signal_delay_measurement #(
  parameter int COUNTER_WIDTH = 8,
  parameter int TIMEOUT_TICKS = 255
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     original_signal,
  input  logic                     delayed_signal,
  output logic                     busy,
  output logic [COUNTER_WIDTH-1:0] measurement,
  output logic                     measurement_valid,
  output logic                     timeout
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMED     = 2'd1,
    MEASURING = 2'd2
  } state_t;

  // State entered after reset and after every completed or timed-out measurement.
`ifdef SIGNAL_DELAY_MEASUREMENT_CONTINUOUS_EN
  localparam state_t REST_STATE = ARMED;
`else
  localparam state_t REST_STATE = IDLE;
`endif

  localparam logic [COUNTER_WIDTH-1:0] TIMEOUT_LIMIT = COUNTER_WIDTH'(TIMEOUT_TICKS);
  localparam logic [COUNTER_WIDTH-1:0] COUNT_ONE     = COUNTER_WIDTH'(1);

  state_t                     state_reg, state_next;
  logic [COUNTER_WIDTH-1:0]   counter_reg, counter_next;
  logic [COUNTER_WIDTH-1:0]   measurement_reg, measurement_next;
  logic                       valid_reg, valid_next;
  logic                       timeout_reg, timeout_next;

  // Bit 0 = reference input, bit 1 = delayed copy.
  logic [1:0] sig_in;
  logic [1:0] rise;

  assign sig_in = {delayed_signal, original_signal};

  // One rising-edge detector per input. The history register resets to 1 so an
  // input that is already high when reset is released does not count as an edge.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_edge
      logic prev_reg;

      // Remember last cycle's input level.
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          prev_reg <= 1'b1;
        end else begin
          prev_reg <= sig_in[gi];
        end
      end

      assign rise[gi] = sig_in[gi] & ~prev_reg;
    end
  endgenerate

  // State, tick counter and registered result outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= REST_STATE;
      counter_reg     <= '0;
      measurement_reg <= '0;
      valid_reg       <= 1'b0;
      timeout_reg     <= 1'b0;
    end else begin
      state_reg       <= state_next;
      counter_reg     <= counter_next;
      measurement_reg <= measurement_next;
      valid_reg       <= valid_next;
      timeout_reg     <= timeout_next;
    end
  end

  // Next-state and result logic; the delayed-edge test wins over the timeout test.
  always_comb begin
    state_next       = state_reg;
    counter_next     = counter_reg;
    measurement_next = measurement_reg;
    valid_next       = 1'b0;
    timeout_next     = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = ARMED;
        end
      end

      ARMED: begin
        if (rise[0] && rise[1]) begin
          // Both edges in the same cycle: zero delay.
          measurement_next = '0;
          valid_next       = 1'b1;
          counter_next     = '0;
          state_next       = REST_STATE;
        end else if (rise[0]) begin
          counter_next = COUNT_ONE;
          state_next   = MEASURING;
        end
        // A lone delayed edge here belongs to an earlier reference; ignore it.
      end

      MEASURING: begin
        if (rise[1]) begin
          measurement_next = counter_reg;
          valid_next       = 1'b1;
          counter_next     = '0;
          state_next       = REST_STATE;
        end else if (counter_reg == TIMEOUT_LIMIT) begin
          timeout_next = 1'b1;
          counter_next = '0;
          state_next   = REST_STATE;
        end else begin
          counter_next = counter_reg + COUNT_ONE;
        end
      end

      default: begin
        state_next   = REST_STATE;
        counter_next = '0;
      end
    endcase
  end

  assign busy              = (state_reg != IDLE);
  assign measurement       = measurement_reg;
  assign measurement_valid = valid_reg;
  assign timeout           = timeout_reg;

endmodule
